// File: rtl/me_pkg.sv
// Shared geometry and pixel type for the motion-estimation pixel feeder.
package me_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int MACRO_DIM_DEF  = 16;
  localparam int SEARCH_DIM_DEF = 48;
  localparam int DATA_W         = 8;
  localparam int PORT_WIDTH     = MACRO_DIM_DEF + 1;
  localparam int NB             = ceil_div(SEARCH_DIM_DEF, PORT_WIDTH);
  localparam int SA_W           = $clog2(SEARCH_DIM_DEF * SEARCH_DIM_DEF);
  localparam int CA_W           = $clog2(MACRO_DIM_DEF * MACRO_DIM_DEF);

  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/me_pixel_feeder_if.sv
// Load port plus pixel stream between the frame-buffer DMA, the feeder and the me core.
interface me_pixel_feeder_if
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = MACRO_DIM_DEF,
  parameter int SEARCH_DIM = SEARCH_DIM_DEF
) ();
  localparam int PW  = MACRO_DIM + 1;
  localparam int SAW = $clog2(SEARCH_DIM * SEARCH_DIM);

  logic           wr_en;
  logic           wr_sel;
  logic [SAW-1:0] wr_addr;
  pixel_t         wr_data;
  logic           restart;
  logic           en_ram;
  pixel_t         pixel_spr_in [0:PW-1];
  pixel_t         pixel_cpr_in [0:MACRO_DIM-1];
  logic           pix_valid;
  logic           done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, restart, en_ram,
    input  pixel_spr_in, pixel_cpr_in, pix_valid, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, restart, en_ram,
    output pixel_spr_in, pixel_cpr_in, pix_valid, done
  );
endinterface

// File: rtl/me_feeder_addr_gen.sv
// Band/column scan counters for the search window; flags the final slice of a pass.
module me_feeder_addr_gen
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = MACRO_DIM_DEF,
  parameter int SEARCH_DIM = SEARCH_DIM_DEF,
  localparam int PW = MACRO_DIM + 1,
  localparam int NBANDS = ceil_div(SEARCH_DIM, PW),
  localparam int BW = (NBANDS > 1) ? $clog2(NBANDS) : 1,
  localparam int CW = $clog2(SEARCH_DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  input  logic          en_ram,
  output logic [BW-1:0] band,
  output logic [CW-1:0] col,
  output logic          done
);

  logic col_last;
  logic band_last;

  assign col_last  = (col == CW'(SEARCH_DIM - 1));
  assign band_last = (band == BW'(NBANDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      band <= '0;
      col  <= '0;
      done <= 1'b0;
    end else if (restart) begin
      band <= '0;
      col  <= '0;
      done <= 1'b0;
    end else if (en_ram) begin
      // done leaves together with the final slice; the next request starts a new pass
      done <= col_last && band_last;
      if (col_last) begin
        col  <= '0;
        band <= band_last ? '0 : band + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/me_pixel_feeder.sv
// Holds one current macroblock and one search window; streams column slices to me on en_ram.
module me_pixel_feeder
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = MACRO_DIM_DEF,
  parameter int SEARCH_DIM = SEARCH_DIM_DEF
) (
  input logic         clk,
  input logic         rst_n,
  me_pixel_feeder_if.slave bus
);
  localparam int PW     = MACRO_DIM + 1;
  localparam int NBANDS = ceil_div(SEARCH_DIM, PW);
  localparam int SSZ    = SEARCH_DIM * SEARCH_DIM;
  localparam int CSZ    = MACRO_DIM * MACRO_DIM;
  localparam int SAW    = $clog2(SSZ);
  localparam int CAW    = $clog2(CSZ);
  localparam int BW     = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int CW     = $clog2(SEARCH_DIM);

  pixel_t s_mem [SSZ];
  pixel_t c_mem [CSZ];

  logic [BW-1:0] band;
  logic [CW-1:0] col;
  logic          done_p1;

  pixel_t spr_rd_p0 [PW];
  pixel_t cpr_rd_p0 [MACRO_DIM];
  pixel_t spr_p1    [PW];
  pixel_t cpr_p1    [MACRO_DIM];
  logic   vld_p1;

  me_feeder_addr_gen #(
    .MACRO_DIM  (MACRO_DIM),
    .SEARCH_DIM (SEARCH_DIM)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (bus.restart),
    .en_ram  (bus.en_ram),
    .band    (band),
    .col     (col),
    .done    (done_p1)
  );

  // Load port: out-of-range addresses are dropped so they never alias into C
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      if (bus.wr_sel) begin
        if (int'(bus.wr_addr) < SSZ) s_mem[bus.wr_addr] <= bus.wr_data;
      end else begin
        if (int'(bus.wr_addr) < CSZ) c_mem[bus.wr_addr[CAW-1:0]] <= bus.wr_data;
      end
    end
  end

  // Stage p0: read ports addressed by the current scan position
  always_comb begin : read_mux
    int row;
    for (int k = 0; k < PW; k++) begin
      row = int'(band) * PW + k;
      if (row < SEARCH_DIM) spr_rd_p0[k] = s_mem[SAW'(row * SEARCH_DIM + int'(col))];
      else                  spr_rd_p0[k] = '0;
    end
    for (int j = 0; j < MACRO_DIM; j++) begin
      cpr_rd_p0[j] = c_mem[CAW'(j * MACRO_DIM + int'(col) % MACRO_DIM)];
    end
  end

  // Stage p1: registered slice presented to me
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < PW; k++) spr_p1[k] <= '0;
      for (int j = 0; j < MACRO_DIM; j++) cpr_p1[j] <= '0;
    end else if (bus.restart) begin
      vld_p1 <= 1'b0;
    end else if (bus.en_ram) begin
      vld_p1 <= 1'b1;
      spr_p1 <= spr_rd_p0;
      cpr_p1 <= cpr_rd_p0;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.pixel_spr_in = spr_p1;
  assign bus.pixel_cpr_in = cpr_p1;
  assign bus.pix_valid    = vld_p1;
  assign bus.done         = done_p1;

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Bench for me_pixel_feeder: reference model feeds a slice scoreboard, plus directed corner sequences.
module tb_me_pixel_feeder;
  import me_pkg::*;

  localparam int MD  = 16;
  localparam int SD  = 48;
  localparam int PW  = MD + 1;
  localparam int NBK = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  me_pixel_feeder_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) bus ();

  me_pixel_feeder #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    pixel_t spr [PW];
    pixel_t cpr [MD];
    bit     done;
  } slice_t;

  typedef struct {
    bit en;
    bit rs;
    bit exp_valid;
  } vec_t;

  slice_t sbq [$];
  slice_t hold_e;
  slice_t zero_e;
  pixel_t s_m [SD*SD];
  pixel_t c_m [MD*MD];
  int     mb, mc;
  int     checks = 0;
  int     failures = 0;
  int     done_cnt;
  logic   seen_valid;
  vec_t   vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_slice(input string name, input slice_t e);
    int bad = -1;
    logic [7:0] a = '0, r = '0;
    checks++;
    for (int k = 0; k < PW; k++)
      if (bad < 0 && bus.pixel_spr_in[k] !== e.spr[k]) begin
        bad = k; a = bus.pixel_spr_in[k]; r = e.spr[k];
      end
    for (int j = 0; j < MD; j++)
      if (bad < 0 && bus.pixel_cpr_in[j] !== e.cpr[j]) begin
        bad = 100 + j; a = bus.pixel_cpr_in[j]; r = e.cpr[j];
      end
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane=%0d (>=100 is cpr) actual=%0h required=%0h at %0t",
               name, bad, a, r, $time);
    end
  endtask

  // One clock: drive inputs, predict from the model, check after the edge.
  task automatic cycle(input bit en, input bit rs, input bit we, input bit sel,
                       input int addr, input int data);
    slice_t e;
    bit exp_v;
    bus.en_ram  = en;
    bus.restart = rs;
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_addr = addr[11:0];
    bus.wr_data = data[7:0];
    exp_v = en && !rs;
    if (rs) begin
      mb = 0; mc = 0;
    end else if (en) begin
      for (int k = 0; k < PW; k++) begin
        int row;
        row = mb * PW + k;
        e.spr[k] = (row < SD) ? s_m[row*SD + mc] : 8'd0;
      end
      for (int j = 0; j < MD; j++) e.cpr[j] = c_m[j*MD + mc % MD];
      e.done = (mb == NBK-1) && (mc == SD-1);
      sbq.push_back(e);
      mc++;
      if (mc == SD) begin
        mc = 0;
        mb = (mb == NBK-1) ? 0 : mb + 1;
      end
    end
    @(posedge clk);
    #1;
    if (we) begin
      if (sel && addr < SD*SD) s_m[addr] = data[7:0];
      if (!sel && addr < MD*MD) c_m[addr] = data[7:0];
    end
    bus.wr_en   = 1'b0;
    bus.en_ram  = 1'b0;
    bus.restart = 1'b0;
    seen_valid  = bus.pix_valid;
    chk("pix_valid", bus.pix_valid, exp_v);
    if (bus.pix_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_slice", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk_slice("slice", e);
        chk("done", bus.done, e.done);
        if (bus.done === 1'b1) done_cnt++;
        hold_e = e;
      end
    end else begin
      chk("done_idle", bus.done, 0);
      chk_slice("hold", hold_e);
    end
  endtask

  task automatic load_mem(input bit sel, input int addr, input int data);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr[11:0]; bus.wr_data = data[7:0];
    @(posedge clk);
    #1;
    if (sel && addr < SD*SD) s_m[addr] = data[7:0];
    if (!sel && addr < MD*MD) c_m[addr] = data[7:0];
    bus.wr_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, bus.pix_valid, 0);
    chk({name, "_done"}, bus.done, 0);
    chk_slice({name, "_pixels"}, zero_e);
  endtask

  initial begin
    for (int k = 0; k < PW; k++) zero_e.spr[k] = '0;
    for (int j = 0; j < MD; j++) zero_e.cpr[j] = '0;
    zero_e.done = 1'b0;
    hold_e = zero_e;
    mb = 0; mc = 0; done_cnt = 0;
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.restart = 0; bus.en_ram = 0;

    vecs[0] = '{en:0, rs:0, exp_valid:0};
    vecs[1] = '{en:1, rs:0, exp_valid:1};
    vecs[2] = '{en:0, rs:0, exp_valid:0};
    vecs[3] = '{en:0, rs:0, exp_valid:0};
    vecs[4] = '{en:1, rs:0, exp_valid:1};
    vecs[5] = '{en:1, rs:0, exp_valid:1};
    vecs[6] = '{en:0, rs:0, exp_valid:0};
    vecs[7] = '{en:1, rs:0, exp_valid:1};

    #11;
    chk_reset_state("por");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < SD*SD; i++) load_mem(1'b1, i, i);
    for (int i = 0; i < MD*MD; i++) load_mem(1'b0, i, i);
    load_mem(1'b0, 300, 8'h55);

    // single consume from band0 col0
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < PW; k++) chk("t2_spr", bus.pixel_spr_in[k], (k*48) & 8'hFF);
    for (int j = 0; j < 4; j++) chk("t2_cpr", bus.pixel_cpr_in[j], j*16);

    // en_ram toggling: valid one cycle late, outputs hold, positions contiguous
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].en, vecs[i].rs, 0, 0, 0, 0);
      chk("tbl_valid", seen_valid, vecs[i].exp_valid);
    end

    // async reset mid-scan
    rst_n = 1'b0;
    #2;
    chk_reset_state("mid_rst");
    mb = 0; mc = 0; sbq.delete(); hold_e = zero_e;
    #2 rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_next_spr1", bus.pixel_spr_in[1], 48);
    chk("rst_next_cpr1", bus.pixel_cpr_in[1], 16);

    // full pass of 144 slices
    cycle(0, 1, 0, 0, 0, 0);
    done_cnt = 0;
    for (int i = 0; i < NBK*SD; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (i == 96)
        for (int k = 0; k < PW; k++)
          chk("t3_slice97", bus.pixel_spr_in[k], (k < 14) ? (((34+k)*48) & 8'hFF) : 0);
      if (i == NBK*SD-1) chk("t3_done_last", bus.done, 1);
    end
    chk("t3_done_count", done_cnt, 1);

    // restart beats en_ram at col 20
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("t5_valid", bus.pix_valid, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t5_spr0", bus.pixel_spr_in[0], 0);
    chk("t5_spr2", bus.pixel_spr_in[2], 96);

    // write S[0] while reading it: old value now, new value next pass
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 8'hAA);
    chk("t6_old", bus.pixel_spr_in[0], 0);
    for (int i = 0; i < NBK*SD-1; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("t6_new", bus.pixel_spr_in[0], 8'hAA);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
